amp_cfg_queue: RTL

Register-write queue and power-up sequencer that sits directly upstream of the amplifier I2C byte engine in the amp frontend. Buffers (register, data) write requests from the system, waits a fixed power-up delay after reset, emits an optional built-in boot sequence, then streams queued writes. Each write is serialised as two bytes over a valid/ready handshake, with `cmd_last` marking the data byte so the I2C side can close the transaction.

---
 rtl/amp_cfg_queue.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/amp_cfg_queue.sv
// amp_cfg_queue: register-write queue and power-up sequencer feeding the
// amplifier I2C byte engine.
//
// Each queued (register, data) write is sent as two bytes on a valid/ready
// handshake. The data byte is flagged with cmd_last.
//
// Optional feature: AMP_CFG_BOOT_SEQ_EN. When defined, a built-in boot table
// is sent after the power-up wait and before any queued write:
// (0x40,0x18) master volume, then (0x35,0x08) I2S input format.
//
// Ports:
//   clk_in, reset         clock; asynchronous active-high reset
//   wr_valid/wr_ready     write-request handshake (wr_reg, wr_data)
//   cmd_valid/cmd_ready   byte handshake toward the I2C engine
//   cmd_byte, cmd_last    register byte, then data byte (last=1)
//   boot_done             power-up wait and boot table finished (sticky)
//   busy                  state is not IDLE
//   fifo_level            number of queued write requests
module amp_cfg_queue #(
    parameter int FIFO_DEPTH   = 4,
    parameter int PWRUP_CYCLES = 1024
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [7:0]                    wr_reg,
    input  logic [7:0]                    wr_data,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [7:0]                    cmd_byte,
    output logic                          cmd_last,
    output logic                          boot_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PWRUP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SREG  = 3'd2,
        ST_SDATA = 3'd3
`ifdef AMP_CFG_BOOT_SEQ_EN
        ,
        ST_BREG  = 3'd4,
        ST_BDATA = 3'd5
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;

    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     level_q, level_d;

    logic            full, empty, push, pop, xfer;
    logic [15:0]     head;

`ifdef AMP_CFG_BOOT_SEQ_EN
    logic            bidx_q, bidx_d;
    logic [15:0]     boot_entry;

    assign boot_entry = bidx_q ? 16'h3508 : 16'h4018;
`endif

    // ---------------- FIFO ----------------
    assign full  = (level_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = wr_valid && !full;
    assign xfer  = cmd_valid && cmd_ready;
    assign pop   = xfer && (state_q == ST_SDATA);
    assign head  = mem_q[rptr_q];

    assign level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wptr_q] <= {wr_reg, wr_data};
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= ST_PWRUP;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef AMP_CFG_BOOT_SEQ_EN
            bidx_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef AMP_CFG_BOOT_SEQ_EN
            bidx_q  <= bidx_d;
`endif
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
`ifdef AMP_CFG_BOOT_SEQ_EN
        bidx_d  = bidx_q;
`endif
        unique case (state_q)
            ST_PWRUP: begin
                if (cnt_q == CW'(PWRUP_CYCLES - 1)) begin
`ifdef AMP_CFG_BOOT_SEQ_EN
                    state_d = ST_BREG;
                    bidx_d  = 1'b0;
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef AMP_CFG_BOOT_SEQ_EN
            ST_BREG: begin
                if (xfer) state_d = ST_BDATA;
            end
            ST_BDATA: begin
                if (xfer) begin
                    if (bidx_q) begin
                        // Go straight to queued writes so there is no
                        // bubble between boot and queued bytes.
                        done_d  = 1'b1;
                        state_d = empty ? ST_IDLE : ST_SREG;
                    end else begin
                        bidx_d  = 1'b1;
                        state_d = ST_BREG;
                    end
                end
            end
`endif
            ST_IDLE: begin
                if (!empty) state_d = ST_SREG;
            end
            ST_SREG: begin
                if (xfer) state_d = ST_SDATA;
            end
            ST_SDATA: begin
                // level_d includes a push landing on the same edge.
                if (xfer) state_d = (level_d != '0) ? ST_SREG : ST_IDLE;
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        cmd_last  = 1'b0;
        unique case (state_q)
`ifdef AMP_CFG_BOOT_SEQ_EN
            ST_BREG: begin
                cmd_valid = 1'b1;
                cmd_byte  = boot_entry[15:8];
            end
            ST_BDATA: begin
                cmd_valid = 1'b1;
                cmd_byte  = boot_entry[7:0];
                cmd_last  = 1'b1;
            end
`endif
            ST_SREG: begin
                cmd_valid = 1'b1;
                cmd_byte  = head[15:8];
            end
            ST_SDATA: begin
                cmd_valid = 1'b1;
                cmd_byte  = head[7:0];
                cmd_last  = 1'b1;
            end
            default: begin
                cmd_valid = 1'b0;
            end
        endcase
    end

    assign wr_ready   = !full;
    assign busy       = (state_q != ST_IDLE);
    assign boot_done  = done_q;
    assign fifo_level = level_q;

endmodule
